// File: rtl/digit_scan_if.sv
// Bundle of the scan controller's enable inputs and display-drive outputs.
interface digit_scan_if;
    logic       en;
    logic [3:0] digit_en;
    logic [1:0] sel;
    logic [3:0] an;
    logic       frame_tick;

    modport master (output en, digit_en, input sel, an, frame_tick);
    modport slave  (input en, digit_en, output sel, an, frame_tick);
endinterface

// File: rtl/digit_scan_ctrl.sv
// 4-digit multiplexed display scanner: Gray-coded digit select, blanking
// guard at the start of every slot, one-cycle frame tick on slot wrap.
module digit_scan_ctrl #(
    parameter int CLK_DIV      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    digit_scan_if.slave bus
);
    if (CLK_DIV < 3 || CLK_DIV > 65535 || BLANK_CYCLES < 1 || BLANK_CYCLES > CLK_DIV - 1)
    begin : g_param_err
        $error("digit_scan_ctrl: illegal CLK_DIV/BLANK_CYCLES");
    end

    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            sel_q   <= '0;
            an_q    <= 4'hF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                slot_d = '0;
                if (bus.en) state_d = BLANK;
            end
            default: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    slot_d  = '0;
                end else if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    slot_d  = slot_q + 2'd1;
                    tick_d  = (slot_q == 2'd3);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q < CW'(BLANK_CYCLES - 1)) ? BLANK : DRIVE;
                end
            end
        endcase

        // Outputs are registered from next state, so sel only moves on the
        // edge that enters BLANK, when every anode is forced off.
        sel_d = slot_d ^ (slot_d >> 1);
        an_d  = 4'hF;
        if (state_d == DRIVE && bus.digit_en[slot_d]) an_d[slot_d] = 1'b0;
    end

    assign bus.sel        = sel_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Drives three parameterisations of the scanner with shared stimulus and
// compares each against a time-since-start arithmetic model every cycle.
module tb_digit_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] de = 4'hF;

    always #5 clk = ~clk;

    localparam int DV [3] = '{8, 3, 16};
    localparam int BV [3] = '{2, 1, 15};

    digit_scan_if if0 ();
    digit_scan_if if1 ();
    digit_scan_if if2 ();

    assign if0.en = en;  assign if0.digit_en = de;
    assign if1.en = en;  assign if1.digit_en = de;
    assign if2.en = en;  assign if2.digit_en = de;

    digit_scan_ctrl #(.CLK_DIV(8),  .BLANK_CYCLES(2))  u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    digit_scan_ctrl #(.CLK_DIV(3),  .BLANK_CYCLES(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    digit_scan_ctrl #(.CLK_DIV(16), .BLANK_CYCLES(15)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [1:0] sel_o [3];
    logic [3:0] an_o  [3];
    logic       tk_o  [3];
    assign sel_o[0] = if0.sel;  assign an_o[0] = if0.an;  assign tk_o[0] = if0.frame_tick;
    assign sel_o[1] = if1.sel;  assign an_o[1] = if1.an;  assign tk_o[1] = if1.frame_tick;
    assign sel_o[2] = if2.sel;  assign an_o[2] = if2.an;  assign tk_o[2] = if2.frame_tick;

    int n_pass = 0;
    int n_chk  = 0;

    // Model: scanning is active or not; t counts cycles since the BLANK entry of slot 0.
    bit         act = 1'b0;
    int         t = 0;
    logic [1:0] prev_sel [3];
    logic [1:0] gray_t [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d t=%0d act=%0d observed=%h expected=%h", tag, k, t, act, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!rst_n) act = 1'b0;
            else if (!act) begin
                if (en) begin act = 1'b1; t = 0; end
            end else if (!en) act = 1'b0;
            else t++;
            for (int k = 0; k < 3; k++) begin
                int slot, c;
                logic [1:0] es;
                logic [3:0] ea;
                logic       et;
                es = 2'b00; ea = 4'hF; et = 1'b0;
                if (act) begin
                    slot = (t / DV[k]) % 4;
                    c    = t % DV[k];
                    es   = gray_t[slot];
                    if (c >= BV[k] && de[slot]) ea = ~(4'b0001 << slot);
                    et   = (t > 0) && (t % (4 * DV[k]) == 0);
                end
                check("sel", k, 32'(sel_o[k]), 32'(es));
                check("an", k, 32'(an_o[k]), 32'(ea));
                check("frame_tick", k, 32'(tk_o[k]), 32'(et));
                if (sel_o[k] !== prev_sel[k]) check("ghost_an_on_sel_change", k, 32'(an_o[k]), 32'hF);
                prev_sel[k] = sel_o[k];
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) prev_sel[k] = 2'b00;
        // reset with en high: must still be idle
        en = 1'b1; rst_n = 1'b0;
        step(2);
        rst_n = 1'b1; en = 1'b0;
        step(3);
        // full frames, all digits
        en = 1'b1; de = 4'hF;
        step(70);
        // alternate digits enabled
        de = 4'b1010;
        step(70);
        // restart, drop en at slot 2 cnt 5, then reassert
        de = 4'hF; en = 1'b0; step(1);
        en = 1'b1; step(1); step(21);
        en = 1'b0; step(2);
        en = 1'b1; step(40);
        // restart, reset pulse in slot 3 drive
        en = 1'b0; step(1);
        en = 1'b1; step(1); step(27);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; step(40);
        // restart, digit_en drops to zero at slot 1 cnt 4
        en = 1'b0; step(1);
        en = 1'b1; step(1); step(12);
        de = 4'h0; step(30);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) de = 4'($urandom);
            if ($urandom_range(63) == 0) en = ~en;
            else if (!en && $urandom_range(3) == 0) en = 1'b1;
            rst_n = ($urandom_range(127) != 0);
            step(1);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 8: clock cycles per digit slot; legal range 3..65535.
REQ-002 Parameter BLANK_CYCLES, default 2: all-anodes-off cycles at the start of each slot; legal range 1..CLK_DIV-1.
REQ-003 Port clk, input, 1: single system clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port en, input, 1: scan enable; 0 forces idle.
REQ-006 Port digit_en, input, 4: per-digit display enable; bit i gates anode i.
REQ-007 Port sel, output, 2: digit-select code driven to the 4:1 digit mux (00=digit0, 01=digit1, 11=digit2, 10=digit3).
REQ-008 Port an, output, 4: anode enables, active-low; bit i corresponds to digit i.
REQ-009 Port frame_tick, output, 1: single-cycle pulse marking completion of a full 4-digit frame.
REQ-010 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-011 States SHALL be IDLE, BLANK and DRIVE; a slot counter cnt (0..CLK_DIV-1) and a slot index slot (0..3) SHALL be kept.
REQ-012 sel SHALL follow Gray order by slot: slot0=00, slot1=01, slot2=11, slot3=10; exactly one sel bit changes per slot advance.
REQ-013 IDLE SHALL hold cnt=0, slot=0, sel=00, an=1111 and frame_tick=0.
REQ-014 In IDLE with en=1 at edge t, the block SHALL be in state BLANK, slot 0, cnt=0 after edge t.
REQ-015 The block SHALL be in BLANK while cnt<BLANK_CYCLES and in DRIVE while BLANK_CYCLES<=cnt<=CLK_DIV-1; each slot SHALL last exactly CLK_DIV cycles.
REQ-016 In BLANK, an SHALL be 1111; in DRIVE, an[i] SHALL be 0 only when i==slot and digit_en[i]==1, with all other bits 1.
REQ-017 digit_en SHALL be sampled every cycle; a mid-slot change SHALL appear on an one cycle later.
REQ-018 At cnt==CLK_DIV-1, the next edge SHALL set cnt=0, advance slot to (slot+1) mod 4 with the matching sel, and enter BLANK.
REQ-019 sel SHALL change only on the edge that enters BLANK, never while any anode is low (ghost-free switching).
REQ-020 frame_tick SHALL be 1 for exactly the one cycle in which slot wraps from 3 to 0; it SHALL be 0 at all other times.
REQ-021 If en=0 at any edge in BLANK or DRIVE, the next cycle SHALL be IDLE per REQ-013, with no frame_tick.
REQ-022 If en is reasserted, scanning SHALL always restart at slot 0 per REQ-014; no partial-frame resume.
REQ-023 With digit_en=0000, timing, sel and frame_tick SHALL be unchanged and an SHALL stay 1111.
REQ-024 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-025 rst_n=0 at an edge SHALL give state IDLE, cnt=0, slot=0, sel=00, an=1111 and frame_tick=0 after that edge, regardless of en.
REQ-026 Reset SHALL take priority over en and over any in-progress slot; after reset, the block SHALL behave per REQ-014 once rst_n=1 and en=1.

Verification
REQ-027 Defaults, rst_n=1, en=1, digit_en=1111 from IDLE -> sel sequence 00,01,11,10 with 8 cycles each; an=1111 for 2 cycles, then an=1110/1101/1011/0111 for 6 cycles each; frame_tick pulses once every 32 cycles, in the cycle sel returns to 00.
REQ-028 digit_en=1010 -> an stays 1111 in slots 0 and 2; an=1101 in slot 1 DRIVE; an=0111 in slot 3 DRIVE; period is still 32 cycles.
REQ-029 en dropped in slot 2 at cnt=5 -> next cycle an=1111, sel=00, frame_tick=0; en reasserted -> slot 0 BLANK, and the first frame_tick arrives 32 cycles later.
REQ-030 rst_n=0 for 1 cycle during slot 3 DRIVE with en=1 -> next cycle an=1111, sel=00, frame_tick=0; with rst_n=1, scanning restarts at slot 0.
REQ-031 digit_en toggled 1111->0000 at slot 1 cnt=4 -> an=1101 until the following edge, then 1111; sel unaffected.
REQ-032 Parameter sweep CLK_DIV=3, BLANK_CYCLES=1 and CLK_DIV=16, BLANK_CYCLES=15 -> slot length, blank length and frame_tick period (4*CLK_DIV) all match; assertion check that an!=1111 never coincides with a sel change.
